// File: rtl/dds_sweep_controller.sv
// Purpose: frequency-sweep sequencer; steps phase_M from start to stop in equal steps, dwell ticks per value.
// Latency: start/abort/sample_tick act on the next clk edge; all outputs are registered.
// Backpressure: cfg_ready is high only in IDLE; config offered during RUN is not accepted.
// Optional feature: define DDS_SWEEP_MARKER_EN to enable the marker threshold comparator.
module dds_sweep_controller #(
  parameter int M_W     = 11,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [M_W-1:0]     cfg_start_m,
  input  logic [M_W-1:0]     cfg_stop_m,
  input  logic [M_W-1:0]     cfg_step_m,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [M_W-1:0]     cfg_marker_m,
  input  logic               start,
  input  logic               abort,
  output logic [M_W-1:0]     phase_M,
  output logic               busy,
  output logic               done,
  output logic               marker
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [M_W-1:0]     start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         mode_q;
  logic [M_W-1:0]     phase_q, phase_d;
  logic [M_W-1:0]     tgt_q, tgt_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic               done_q, done_d;

  logic               hs;
  logic [M_W-1:0]     eff_start, eff_stop, eff_step, step_eff;
  logic [DWELL_W-1:0] eff_dwell, dwell_eff;
  logic [1:0]         eff_mode;
  logic               step_due, at_end, mode_saw, mode_tri;

  // A handshake in the same cycle as start must take effect immediately,
  // so the sweep always reads config through these bypass muxes.
  assign hs        = cfg_valid && cfg_ready;
  assign eff_start = hs ? cfg_start_m : start_q;
  assign eff_stop  = hs ? cfg_stop_m  : stop_q;
  assign eff_step  = hs ? cfg_step_m  : step_q;
  assign eff_dwell = hs ? cfg_dwell   : dwell_q;
  assign eff_mode  = hs ? cfg_mode    : mode_q;
  assign step_eff  = (eff_step  == '0) ? M_W'(1)     : eff_step;
  assign dwell_eff = (eff_dwell == '0) ? DWELL_W'(1) : eff_dwell;
  assign mode_saw  = (eff_mode == 2'b01);
  assign mode_tri  = (eff_mode == 2'b10);

  // The current value has served its last dwell tick.
  assign step_due  = (state_q == RUN) && sample_tick && (cnt_q == DWELL_W'(1));
  assign at_end    = step_due && (phase_q == tgt_q);

  // Move one step toward tgt; the extra bit catches overflow/underflow so the
  // result clamps at tgt instead of wrapping.
  function automatic logic [M_W-1:0] step_toward(input logic [M_W-1:0] cur,
                                                 input logic [M_W-1:0] tgt,
                                                 input logic [M_W-1:0] stp,
                                                 input logic           up);
    logic [M_W:0] nxt;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      if (nxt >= {1'b0, tgt}) nxt = {1'b0, tgt};
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      if (nxt[M_W] || (nxt <= {1'b0, tgt})) nxt = {1'b0, tgt};
    end
    return nxt[M_W-1:0];
  endfunction

  // State, sweep datapath and latched config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      mode_q   <= '0;
      phase_q  <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      dir_up_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      done_q   <= done_d;
      if (hs) begin
        start_q <= cfg_start_m;
        stop_q  <= cfg_stop_m;
        step_q  <= cfg_step_m;
        dwell_q <= cfg_dwell;
        mode_q  <= cfg_mode;
      end
    end
  end

  // Next state: abort beats start and any endpoint; only single mode exits on its own.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = RUN;
      RUN:     if (abort || (at_end && !mode_saw && !mode_tri)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next phase word, dwell counter, direction/target and done pulse.
  always_comb begin
    phase_d  = phase_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    done_d   = 1'b0;
    if (abort) begin
      phase_d = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        phase_d  = eff_start;
        tgt_d    = eff_stop;
        cnt_d    = dwell_eff;
        dir_up_d = (eff_start <= eff_stop);
      end
    end else if (sample_tick) begin
      if (cnt_q != DWELL_W'(1)) begin
        cnt_d = cnt_q - DWELL_W'(1);
      end else begin
        cnt_d = dwell_eff;
        if (phase_q != tgt_q) begin
          phase_d = step_toward(phase_q, tgt_q, step_eff, dir_up_q);
        end else if (mode_saw) begin
          phase_d = eff_start;
        end else if (mode_tri) begin
          // Turn around without repeating the endpoint: step straight away from it.
          dir_up_d = !dir_up_q;
          tgt_d    = (tgt_q == eff_stop) ? eff_start : eff_stop;
          phase_d  = step_toward(phase_q, tgt_d, step_eff, dir_up_d);
        end else begin
          phase_d = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign phase_M   = phase_q;
  assign done      = done_q;

`ifdef DDS_SWEEP_MARKER_EN
  logic [M_W-1:0] mk_q, eff_mk;
  logic           marker_q, marker_d;

  assign eff_mk = hs ? cfg_marker_m : mk_q;

  // Marker is evaluated on the next phase word so it changes in step with phase_M.
  always_comb begin
    marker_d = 1'b0;
    if (state_d == RUN) marker_d = dir_up_d ? (phase_d >= eff_mk) : (phase_d <= eff_mk);
  end

  // Marker threshold latch and registered marker level.
  always_ff @(posedge clk) begin
    if (rst) begin
      mk_q     <= '0;
      marker_q <= 1'b0;
    end else begin
      marker_q <= marker_d;
      if (hs) mk_q <= cfg_marker_m;
    end
  end

  assign marker = marker_q;
`else
  logic unused_marker_m;
  assign unused_marker_m = ^cfg_marker_m;
  assign marker          = 1'b0;
`endif

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed bench for dds_sweep_controller: single, triangle, sawtooth sweeps,
// abort priority, clamping, equal endpoints, mid-sweep reset and the marker level.
module tb_dds_sweep_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [10:0] cfg_start_m = '0;
  logic [10:0] cfg_stop_m = '0;
  logic [10:0] cfg_step_m = '0;
  logic [15:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic [10:0] cfg_marker_m = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] phase_M;
  logic        busy, done, marker;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  dds_sweep_controller #(.M_W(11), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_m(cfg_start_m), .cfg_stop_m(cfg_stop_m), .cfg_step_m(cfg_step_m),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_marker_m(cfg_marker_m),
    .start(start), .abort(abort),
    .phase_M(phase_M), .busy(busy), .done(done), .marker(marker)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic clk1();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic set_cfg(input int s, input int t, input int st, input int d, input int m, input int mk);
    cfg_start_m  = 11'(s);
    cfg_stop_m   = 11'(t);
    cfg_step_m   = 11'(st);
    cfg_dwell    = 16'(d);
    cfg_mode     = 2'(m);
    cfg_marker_m = 11'(mk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk1();
    clk1();
    tests_run++;
    if (phase_M !== 11'd0) begin tests_failed++; $display("FAIL reset_phase: got %0d expected 0", phase_M); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++;
    if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    tests_run++;
    if (marker !== 1'b0) begin tests_failed++; $display("FAIL reset_marker: got %b expected 0", marker); end
    rst = 1'b0;
    clk1();
  endtask

  // Up sweep 100..130 step 10, dwell 3, one tick every 4 clocks.
  task automatic test_single();
    int ev[4];
    ev = '{100, 110, 120, 130};
    set_cfg(100, 130, 10, 3, 0, 0);
    cfg_valid = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b1;
    done_cnt = 0;
    clk1();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (phase_M !== 11'(ev[i]) || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL single_step%0d_tick%0d: got phase %0d busy %b expected phase %0d busy 1", i, k, phase_M, busy, ev[i]);
        end
        sample_tick = 1'b1;
        clk1();
        sample_tick = 1'b0;
        clk1(); clk1(); clk1();
      end
    end
    tests_run++;
    if (phase_M !== 11'd0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_end: got phase %0d busy %b expected phase 0 busy 0", phase_M, busy);
    end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
  endtask

  // Down-first triangle, handshake and start in the same cycle.
  task automatic test_triangle();
    int ev[13];
    ev = '{130, 123, 116, 109, 102, 100, 107, 114, 121, 128, 130, 123, 116};
    set_cfg(130, 100, 7, 1, 2, 0);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    sample_tick = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tests_run++;
      if (phase_M !== 11'(ev[i])) begin
        tests_failed++; $display("FAIL triangle_val%0d: got %0d expected %0d", i, phase_M, ev[i]);
      end
      clk1();
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL triangle_busy: got %b expected 1", busy); end
  endtask

  // Abort together with start and tick while the triangle is still running.
  task automatic test_abort();
    done_cnt = 0;
    abort = 1'b1;
    start = 1'b1;
    sample_tick = 1'b1;
    clk1();
    abort = 1'b0;
    start = 1'b0;
    sample_tick = 1'b0;
    tests_run++;
    if (phase_M !== 11'd0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL abort_outputs: got phase %0d busy %b expected phase 0 busy 0", phase_M, busy);
    end
    tests_run++;
    if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_cfg_ready: got %b expected 1", cfg_ready); end
    clk1(); clk1(); clk1();
    tests_run++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL abort_no_done: got done count %0d busy %b expected 0 and 0", done_cnt, busy);
    end
  endtask

  // Zero step and dwell act as 1; config and start offered during RUN are ignored.
  task automatic test_sawtooth();
    int ev[7];
    ev = '{5, 6, 7, 5, 6, 7, 5};
    set_cfg(5, 7, 0, 0, 1, 0);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    sample_tick = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (phase_M !== 11'(ev[i])) begin
        tests_failed++; $display("FAIL sawtooth_val%0d: got %0d expected %0d", i, phase_M, ev[i]);
      end
      if (i == 2) begin
        set_cfg(50, 60, 3, 4, 0, 0);
        cfg_valid = 1'b1;
        start = 1'b1;
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL sawtooth_cfg_ready: got %b expected 0", cfg_ready); end
      end
      clk1();
      cfg_valid = 1'b0;
      start = 1'b0;
    end
    sample_tick = 1'b0;
    abort = 1'b1;
    clk1();
    abort = 1'b0;
    tests_run++;
    if (phase_M !== 11'd0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL sawtooth_abort: got phase %0d busy %b expected phase 0 busy 0", phase_M, busy);
    end
  endtask

  // start == stop in single mode: hold for the dwell, then complete.
  task automatic test_equal_endpoints();
    set_cfg(20, 20, 4, 2, 3, 0);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    sample_tick = 1'b1;
    clk1();
    tests_run++;
    if (phase_M !== 11'd20 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL equal_hold: got phase %0d busy %b expected phase 20 busy 1", phase_M, busy);
    end
    clk1();
    sample_tick = 1'b0;
    tests_run++;
    if (phase_M !== 11'd0 || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL equal_done: got phase %0d done %b busy %b expected 0 1 0", phase_M, done, busy);
    end
    clk1();
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL equal_done_pulse: got %b expected 0", done); end
  endtask

  // Steps that would overflow the top or go below zero clamp to the stop value.
  task automatic test_clamp();
    set_cfg(2040, 2047, 100, 1, 0, 0);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    sample_tick = 1'b1;
    clk1();
    tests_run++;
    if (phase_M !== 11'd2047) begin tests_failed++; $display("FAIL clamp_up: got %0d expected 2047", phase_M); end
    clk1();
    tests_run++;
    if (phase_M !== 11'd0 || done !== 1'b1) begin
      tests_failed++; $display("FAIL clamp_up_done: got phase %0d done %b expected 0 1", phase_M, done);
    end
    sample_tick = 1'b0;
    set_cfg(3, 0, 5, 1, 0, 0);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    tests_run++;
    if (phase_M !== 11'd3) begin tests_failed++; $display("FAIL clamp_down_start: got %0d expected 3", phase_M); end
    sample_tick = 1'b1;
    clk1();
    tests_run++;
    if (phase_M !== 11'd0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL clamp_down: got phase %0d busy %b expected phase 0 busy 1", phase_M, busy);
    end
    clk1();
    sample_tick = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL clamp_down_done: got done %b busy %b expected 1 0", done, busy);
    end
    clk1();
  endtask

  // Reset mid-sweep clears outputs and the latched config.
  task automatic test_reset_mid_sweep();
    set_cfg(5, 7, 1, 1, 1, 0);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    sample_tick = 1'b1;
    clk1();
    sample_tick = 1'b0;
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    tests_run++;
    if (phase_M !== 11'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL midreset: got phase %0d busy %b cfg_ready %b expected 0 0 1", phase_M, busy, cfg_ready);
    end
    start = 1'b1;
    clk1();
    start = 1'b0;
    tests_run++;
    if (phase_M !== 11'd0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_cfg_cleared: got phase %0d busy %b expected phase 0 busy 1", phase_M, busy);
    end
    sample_tick = 1'b1;
    clk1();
    sample_tick = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL midreset_zero_sweep_done: got %b expected 1", done); end
    clk1();
  endtask

  // Marker rises once phase_M reaches the threshold and clears on completion.
  task automatic test_marker();
    int ev[6];
    logic em[6];
    ev = '{0, 10, 20, 30, 40, 0};
`ifdef DDS_SWEEP_MARKER_EN
    em = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    em = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    set_cfg(0, 40, 10, 1, 0, 25);
    cfg_valid = 1'b1;
    start = 1'b1;
    clk1();
    cfg_valid = 1'b0;
    start = 1'b0;
    sample_tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (phase_M !== 11'(ev[i]) || marker !== em[i]) begin
        tests_failed++;
        $display("FAIL marker_val%0d: got phase %0d marker %b expected phase %0d marker %b", i, phase_M, marker, ev[i], em[i]);
      end
      if (i < 5) clk1();
    end
    sample_tick = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL marker_done: got %b expected 1", done); end
    clk1();
  endtask

  initial begin
    test_reset();
    test_single();
    test_triangle();
    test_abort();
    test_sawtooth();
    test_equal_endpoints();
    test_clamp();
    test_reset_mid_sweep();
    test_marker();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
